// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result bundle between a shift requester and the shift_seq engine.
interface shift_seq_if #(
  parameter int OPSIZE = 2,
  parameter int DSIZE  = 16,
  parameter int CSIZE  = 4
);
  logic              start;
  logic [OPSIZE-1:0] op;
  logic              inv;
  logic [CSIZE-1:0]  amt;
  logic [DSIZE-1:0]  data_in;
  logic              busy;
  logic              done;
  logic [DSIZE-1:0]  f;
  modport master (output start, op, inv, amt, data_in, input busy, done, f);
  modport slave  (input start, op, inv, amt, data_in, output busy, done, f);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: iterative shift/rotate engine applying one 1-bit SRL/SLL/ROR/ROL step per clock.
module shift_seq #(
  parameter int OPSIZE = 2,
  parameter int DSIZE  = 16,
  parameter int CSIZE  = 4
) (
  input  logic clk,
  input  logic rst_n,
  shift_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state, state_nx;
  logic [DSIZE-1:0]  f, f_nx;
  logic [CSIZE-1:0]  cnt, cnt_nx;
  logic [OPSIZE-1:0] eop, eop_nx;
  function automatic logic [DSIZE-1:0] step(input logic [DSIZE-1:0] x, input logic [OPSIZE-1:0] e);
    return e[1] ? (e[0] ? {x[DSIZE-2:0], x[DSIZE-1]} : {x[0], x[DSIZE-1:1]})
                : (e[0] ? x << 1 : x >> 1);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      f     <= '0;
      cnt   <= '0;
      eop   <= '0;
    end else begin
      state <= state_nx;
      f     <= f_nx;
      cnt   <= cnt_nx;
      eop   <= eop_nx;
    end
  // inv flips the left/right bit so the same op code undoes a previous result
  always_comb begin
    state_nx = state;
    f_nx     = f;
    cnt_nx   = cnt;
    eop_nx   = eop;
    case (state)
      IDLE:
        if (bus.start) begin
          f_nx     = bus.data_in;
          cnt_nx   = bus.amt;
          eop_nx   = bus.op ^ OPSIZE'(bus.inv);
          state_nx = (bus.amt == '0) ? DONE : SHIFT;
        end
      SHIFT: begin
        f_nx     = step(f, eop);
        cnt_nx   = cnt - CSIZE'(1);
        state_nx = (cnt == CSIZE'(1)) ? DONE : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.f    = f;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and randomized checks of shift_seq against an arithmetic shift/rotate model.
module tb_shift_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  shift_seq_if #(.OPSIZE(2), .DSIZE(16), .CSIZE(4)) intf ();
  shift_seq #(.OPSIZE(2), .DSIZE(16), .CSIZE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(intf.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic inv, input int n, input logic [15:0] x);
    logic [1:0] e;
    logic [31:0] d;
    e = op ^ {1'b0, inv};
    case (e)
      2'b00: return x >> n;
      2'b01: return x << n;
      2'b10: begin d = {x, x} >> n; return d[15:0]; end
      default: begin d = {x, x} << n; return d[31:16]; end
    endcase
  endfunction

  // Runs one operation; interfere re-pulses start with junk inputs during the first SHIFT cycle.
  task automatic run(input string tag, input logic [1:0] op, input logic inv, input int amt,
                     input logic [15:0] x, input logic [15:0] exp, input bit interfere);
    int cyc, nbusy;
    @(negedge clk);
    intf.start = 1'b1; intf.op = op; intf.inv = inv; intf.amt = 4'(amt); intf.data_in = x;
    @(posedge clk); #1;
    intf.start = 1'b0;
    intf.data_in = 16'h0;
    cyc = 1; nbusy = 0;
    while (!intf.done && cyc < 40) begin
      if (intf.busy) nbusy++;
      if (interfere && cyc == 1) begin
        intf.start = 1'b1; intf.data_in = 16'hFFFF; intf.op = 2'($urandom); intf.amt = 4'($urandom);
      end else begin
        intf.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    intf.start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(amt + 1));
    chk({tag, "_busy"}, 32'(nbusy), 32'(amt));
    chk({tag, "_f"}, 32'(intf.f), 32'(exp));
    @(posedge clk); #1;
    chk({tag, "_post"}, {14'h0, intf.busy, intf.done, intf.f}, {16'h0, exp});
  endtask

  initial begin
    logic [1:0] rop;
    logic rinv;
    int ramt, dcnt;
    logic [15:0] rx;
    intf.start = 1'b0; intf.op = 2'b00; intf.inv = 1'b0; intf.amt = 4'h0; intf.data_in = 16'h0;
    #12;
    chk("reset", {14'h0, intf.busy, intf.done, intf.f}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_hold", {14'h0, intf.busy, intf.done, intf.f}, 32'h0);
    run("srl", 2'b00, 1'b0, 3, 16'h8001, 16'h1000, 1'b0);
    run("rol", 2'b11, 1'b0, 4, 16'h8001, 16'h0018, 1'b0);
    run("rol_inv", 2'b11, 1'b1, 4, 16'h0018, 16'h8001, 1'b0);
    run("ror15", 2'b10, 1'b0, 15, 16'h0001, 16'h0002, 1'b0);
    run("sll_inv", 2'b01, 1'b1, 4, 16'h00F0, 16'h000F, 1'b0);
    run("amt0", 2'b01, 1'b0, 0, 16'hABCD, 16'hABCD, 1'b0);
    run("ignore_start", 2'b00, 1'b0, 3, 16'h8001, 16'h1000, 1'b0 | 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("hold_f", 32'(intf.f), 32'h1000);
    @(negedge clk);
    intf.start = 1'b1; intf.op = 2'b00; intf.inv = 1'b0; intf.amt = 4'd3; intf.data_in = 16'h8001;
    @(posedge clk); #1 intf.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("abort", {14'h0, intf.busy, intf.done, intf.f}, 32'h0);
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); #1 if (intf.done) dcnt++;
    end
    chk("abort_nodone", 32'(dcnt), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    run("after_rst", 2'b10, 1'b0, 5, 16'h1234, model(2'b10, 1'b0, 5, 16'h1234), 1'b0);
    for (int i = 0; i < 25; i++) begin
      rop = 2'($urandom); rinv = 1'($urandom); ramt = int'($urandom_range(0, 15)); rx = 16'($urandom);
      run($sformatf("rnd%0d", i), rop, rinv, ramt, rx, model(rop, rinv, ramt, rx), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
